// File: rtl/lr1_inv_search_if.sv
// Request/stream interface for the LR1 inverse-search block.
interface lr1_inv_search_if;
    logic       start;
    logic [3:0] y_in;
    logic       busy;
    logic       x_valid;
    logic [3:0] x_out;
    logic       done;
    logic [4:0] count;
    logic       found;

    modport master (
        output start, y_in,
        input  busy, x_valid, x_out, done, count, found
    );

    modport slave (
        input  start, y_in,
        output busy, x_valid, x_out, done, count, found
    );
endinterface

// File: rtl/lr1_inv_search.sv
// Sequential preimage search of the LR1 4-bit S-box: scans X=0..F and
// streams every X whose forward image equals the latched Y.
module lr1_inv_search #(
    parameter int unsigned EARLY_STOP = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    lr1_inv_search_if.slave  bus
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 5;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             r_state, w_state;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [3:0]         r_y, w_y;
    logic               r_busy, w_busy;
    logic               r_x_valid, w_x_valid;
    logic [3:0]         r_x_out, w_x_out;
    logic               r_done, w_done;
    logic [CNT_W-1:0]   r_count, w_count;
    logic               r_found, w_found;
    logic               w_match;

    // Forward LR1 substitution table
    function automatic logic [3:0] fwd(input logic [3:0] x);
        case (x)
            4'h0: fwd = 4'h8;  4'h1: fwd = 4'h5;  4'h2: fwd = 4'h2;  4'h3: fwd = 4'hA;
            4'h4: fwd = 4'hE;  4'h5: fwd = 4'h8;  4'h6: fwd = 4'h9;  4'h7: fwd = 4'h7;
            4'h8: fwd = 4'h5;  4'h9: fwd = 4'hF;  4'hA: fwd = 4'hB;  4'hB: fwd = 4'h4;
            4'hC: fwd = 4'h8;  4'hD: fwd = 4'hC;  4'hE: fwd = 4'h1;  default: fwd = 4'h0;
        endcase
    endfunction

    assign w_match = (fwd(r_idx) == r_y);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_y       <= '0;
            r_busy    <= 1'b0;
            r_x_valid <= 1'b0;
            r_x_out   <= '0;
            r_done    <= 1'b0;
            r_count   <= '0;
            r_found   <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_y       <= w_y;
            r_busy    <= w_busy;
            r_x_valid <= w_x_valid;
            r_x_out   <= w_x_out;
            r_done    <= w_done;
            r_count   <= w_count;
            r_found   <= w_found;
        end
    end

    // Next-state and registered-output logic; strobes default low
    always_comb begin
        w_state   = r_state;
        w_idx     = r_idx;
        w_y       = r_y;
        w_busy    = r_busy;
        w_x_valid = 1'b0;
        w_x_out   = r_x_out;
        w_done    = 1'b0;
        w_count   = r_count;
        w_found   = r_found;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_y     = bus.y_in;
                    w_idx   = '0;
                    w_count = '0;
                    w_found = 1'b0;
                    w_busy  = 1'b1;
                    w_state = SCAN;
                end
            end
            SCAN: begin
                if (w_match) begin
                    w_x_valid = 1'b1;
                    w_x_out   = r_idx;
                    w_count   = r_count + CNT_W'(1);
                end
                w_idx = r_idx + IDX_W'(1);
                if ((r_idx == IDX_W'(15)) || ((EARLY_STOP != 0) && w_match)) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_found = (w_count != '0);
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign bus.busy    = r_busy;
    assign bus.x_valid = r_x_valid;
    assign bus.x_out   = r_x_out;
    assign bus.done    = r_done;
    assign bus.count   = r_count;
    assign bus.found   = r_found;

endmodule

// File: doc/lr1_inv_search.md
Name: lr1_inv_search

Overview:
- Inverse of the LR1 4-bit substitution table (forward map X->Y).
- The forward map is not a bijection, so the block does not invert it combinationally. It sequentially scans all 16 X candidates and streams out every X whose image equals a requested Y.
- Reports the match count at the end of the scan.
- Used by lab benches and the LR1 self-check path to recover preimages of S-box outputs.

Parameters:
- EARLY_STOP, 0, 0 = scan all 16 candidates; 1 = terminate the scan at the first match.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous reset, active-high
- START  input  1  scan request, sampled only when BUSY=0
- Y_IN  input  4  target S-box output value, latched on accepted START
- BUSY  output  1  scan in progress
- X_VALID  output  1  one-cycle strobe: X_OUT holds a preimage of the latched Y
- X_OUT  output  4  matching X value; updates only on a match, otherwise holds
- DONE  output  1  one-cycle strobe: scan finished, COUNT/FOUND final
- COUNT  output  5  number of matches found in current/last scan (0..16)
- FOUND  output  1  COUNT!=0, valid from DONE until next accepted START

Behaviour:
- One clock CLK; RST synchronous, active-high.
- Reset values: BUSY=0, X_VALID=0, X_OUT=0, DONE=0, COUNT=0, FOUND=0, state=IDLE, index=0, Y latch=0.
- Internal forward table, hex X:Y:
  - 0:8 1:5 2:2 3:A 4:E 5:8 6:9 7:7
  - 8:5 9:F A:B B:4 C:8 D:C E:1 F:0
- Values 3, 6 and D have no preimage. 8 has three preimages (0, 5, C). 5 has two (1, 8). All other images have exactly one.
- States: IDLE, SCAN. DONE is a registered strobe, not a state.
- IDLE:
  - On START=1 at edge 0: latch Y_IN, index<=0, COUNT<=0, FOUND<=0, BUSY<=1, go to SCAN.
- SCAN, at edge n (n=1..16), evaluate index i=n-1 by comparing table[i] with the latched Y:
  - match: X_VALID<=1, X_OUT<=i, COUNT<=COUNT+1.
  - no match: X_VALID<=0, X_OUT unchanged.
  - index<=i+1.
- Scan termination:
  - Normal end: at the edge evaluating i=15 (edge 16), also DONE<=1, BUSY<=0, FOUND<=(final COUNT!=0), go to IDLE.
  - EARLY_STOP=1 and a match at edge i+1: the same edge sets DONE<=1, BUSY<=0, FOUND<=1, go to IDLE. No further candidates are evaluated.
- Latency:
  - Match at index i: X_VALID high in the cycle following edge i+1.
  - DONE high in the cycle following edge 16 (EARLY_STOP=0 or no match).
  - The final X_VALID and DONE may be high in the same cycle.
- X_VALID and DONE are strobes, cleared on the following edge unless re-asserted.
- COUNT, FOUND and X_OUT hold after DONE until the next accepted START.
- START while BUSY=1: ignored; the scan continues undisturbed.
- START in the DONE cycle (BUSY already 0): accepted, giving back-to-back scans with no idle gap.
- Y_IN changes during a scan: ignored; only the latched value is used.
- RST during a scan: all outputs return to reset values at that edge; no DONE is emitted.
- COUNT cannot overflow (max 16 fits in 5 bits); the scan index wraps 15->0 only via START.

Test Plan:
- Y_IN=8, START pulse, EARLY_STOP=0 -> X_VALID after edges 1, 6, 13 with X_OUT=0, 5, C; DONE after edge 16; COUNT=3, FOUND=1, X_OUT holds C.
- Y_IN=3, START -> no X_VALID for 16 cycles; DONE after edge 16; COUNT=0, FOUND=0, X_OUT unchanged.
- EARLY_STOP=1, Y_IN=5, START -> X_VALID and DONE together after edge 2 with X_OUT=1; COUNT=1; BUSY low from that cycle; X=8 never reported.
- Y_IN=0, START; START pulsed with Y_IN=8 at edge 5 -> ignored; single match X_OUT=F after edge 16; COUNT=1. Then START with Y_IN=C during the DONE cycle -> accepted, X_VALID with D after the following 14th edge, COUNT=1.
- Y_IN=8, START, RST asserted at edge 7 -> all outputs 0 after edge 7, no DONE. The next START with Y_IN=2 yields a clean scan: X_OUT=2, COUNT=1.
- Sweep Y_IN 0..F, one scan each -> COUNT per value matches the table preimage counts; the sum of COUNT over all 16 scans is 16.
